// File: rtl/umem_arbiter_pkg.sv
// rtl/umem_arbiter_pkg.sv - shared size codes, arbiter state/owner types, access check
package umem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, M_REQ, M_WAIT, RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    // Unsupported size codes are rejected exactly like misaligned accesses.
    function automatic logic access_error(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: access_error = 1'b0;
            F3_H, F3_HU: access_error = lo[0];
            F3_W:        access_error = |lo;
            default:     access_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/umem_lane_align.sv
// rtl/umem_lane_align.sv - byte-lane strobes, store data shift, load extraction/extension
module umem_lane_align
    import umem_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0] sh;

    assign wdata_sh = wdata << {lo, 3'b000};
    assign sh       = rdata >> {lo, 3'b000};

    always_comb begin
        wstrb = 4'b0000;
        if (we) begin
            case (funct3[1:0])
                2'b00:   wstrb = 4'b0001 << lo;
                2'b01:   wstrb = 4'b0011 << {lo[1], 1'b0};
                default: wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        rdata_ext = sh;
        case (funct3)
            F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   rdata_ext = {24'h0, sh[7:0]};
            F3_H:    rdata_ext = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   rdata_ext = {16'h0, sh[15:0]};
            default: rdata_ext = sh;
        endcase
    end

endmodule

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - fetch/load-store arbiter for the single unified-memory port
module umem_arbiter
    import umem_arbiter_pkg::*;
#(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          MAX_DSTREAK = 4,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_wstrb,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int DSW = $clog2(MAX_DSTREAK + 1);

    arb_state_e      state, state_nx;
    owner_e          owner;
    logic            r_we;
    logic [2:0]      r_f3;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DSW-1:0]  dstreak;
    logic [TW-1:0]   tcnt;
    logic            resp_err;
    logic [DW-1:0]   resp_data;

    logic            fetch_turn, grant_d, grant_if, d_bad, done, expired, in_mem;
    logic [3:0]      lane_wstrb;
    logic [31:0]     lane_wdata, lane_rdata;

    umem_lane_align u_align (
        .funct3    (r_f3),
        .lo        (r_addr[1:0]),
        .we        (r_we),
        .wdata     (r_wdata),
        .rdata     (m_rdata),
        .wstrb     (lane_wstrb),
        .wdata_sh  (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Fetch wins only once data has used up its streak allowance.
    assign fetch_turn = if_req && (dstreak == DSW'(MAX_DSTREAK));
    assign grant_d    = (state == IDLE) && d_req && !fetch_turn;
    assign grant_if   = (state == IDLE) && if_req && !grant_d;
    assign d_bad      = access_error(d_funct3, d_addr[1:0]);
    assign in_mem     = (state == M_REQ) || (state == M_WAIT);
    assign done       = ((state == M_REQ) && m_gnt && m_rvalid) || ((state == M_WAIT) && m_rvalid);
    assign expired    = in_mem && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_d)       state_nx = d_bad ? RESP : M_REQ;
                else if (grant_if) state_nx = M_REQ;
            end
            M_REQ: begin
                if (done || expired) state_nx = RESP;
                else if (m_gnt)      state_nx = M_WAIT;
            end
            M_WAIT: if (done || expired) state_nx = RESP;
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            r_we      <= 1'b0;
            r_f3      <= F3_W;
            r_addr    <= '0;
            r_wdata   <= '0;
            dstreak   <= '0;
            tcnt      <= '0;
            resp_err  <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= state_nx;

            if (!if_req || grant_if)
                dstreak <= '0;
            else if (grant_d && dstreak != DSW'(MAX_DSTREAK))
                dstreak <= dstreak + DSW'(1);

            if (in_mem)
                tcnt <= tcnt + TW'(1);

            if (grant_if) begin
                owner   <= OWN_IF;
                r_we    <= 1'b0;
                r_f3    <= F3_W;
                r_addr  <= if_addr;
                r_wdata <= '0;
                tcnt    <= '0;
            end else if (grant_d) begin
                owner   <= OWN_D;
                r_we    <= d_we;
                r_f3    <= d_funct3;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                tcnt    <= '0;
                if (d_bad) begin
                    resp_err  <= 1'b1;
                    resp_data <= ERR_DATA;
                end
            end

            if (done) begin
                resp_err  <= 1'b0;
                resp_data <= (owner == OWN_IF) ? m_rdata : (r_we ? '0 : lane_rdata);
            end else if (expired) begin
                resp_err  <= 1'b1;
                resp_data <= ERR_DATA;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign m_req     = (state == M_REQ);
    assign m_we      = m_req && r_we;
    assign m_addr    = m_req ? {r_addr[AW-1:2], 2'b00} : '0;
    assign m_wdata   = m_we ? lane_wdata : '0;
    assign m_wstrb   = m_we ? lane_wstrb : 4'b0000;
    assign if_rvalid = (state == RESP) && (owner == OWN_IF);
    assign d_rvalid  = (state == RESP) && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? resp_data : '0;
    assign d_rdata   = d_rvalid ? resp_data : '0;
    assign if_err    = if_rvalid && resp_err;
    assign d_err     = d_rvalid && resp_err;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - directed plus randomized self-checking bench for umem_arbiter
module tb_umem_arbiter;

    logic        clk, nreset;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    umem_arbiter dut (
        .clk(clk), .nreset(nreset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction. gw: M_REQ cycles before m_gnt; rw: cycles from m_gnt to m_rvalid.
    task automatic txn(input bit isf, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] word, input int gw, input int rw);
        int a, sz, kc, kexp, k;
        bit mis, terr, got;
        logic [3:0]  strb;
        logic [31:0] wexp, rexp;
        a  = int'(addr[1:0]);
        sz = isf ? 4 : (f3[1:0] == 2'b00 ? 1 : (f3[1:0] == 2'b01 ? 2 : 4));
        mis = !isf && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (a % sz) != 0);
        kc   = 1 + gw + rw;
        terr = !mis && kc > 64;
        kexp = mis ? 1 : (terr ? 65 : kc + 1);
        strb = 4'b0000;
        wexp = 32'h0;
        for (int i = 0; i < 4; i++) begin
            strb[i] = !isf && we && i >= a && i < a + sz;
            if (i >= a) wexp[8*i +: 8] = wd[8*(i-a) +: 8];
        end
        if (mis || terr)  rexp = ERRD;
        else if (isf)     rexp = word;
        else if (we)      rexp = 32'h0;
        else begin
            rexp = 32'h0;
            for (int i = 0; i < sz; i++) rexp[8*i +: 8] = word[8*(a+i) +: 8];
            if (!f3[2] && sz < 4 && rexp[8*sz-1]) rexp = rexp | (32'hFFFFFFFF << (8*sz));
        end

        if (isf) begin if_req = 1'b1; if_addr = addr; end
        else begin d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd; end
        #1;
        chk("gnt", {30'h0, if_gnt, d_gnt}, isf ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_funct3 = 3'($urandom); d_we = 1'($urandom);
        k = 1; got = 0;
        while (!got && k < 100) begin
            m_gnt    = (k == 1 + gw);
            m_rvalid = (k == kc);
            m_rdata  = m_rvalid ? word : $urandom;
            #1;
            if (k == 1) begin
                chk("m_req", {31'h0, m_req}, {31'h0, !mis});
                if (!mis) begin
                    chk("m_addr", m_addr, {addr[31:2], 2'b00});
                    chk("m_we", {31'h0, m_we}, {31'h0, !isf && we});
                    chk("m_wstrb", {28'h0, m_wstrb}, {28'h0, strb});
                    if (!isf && we) chk("m_wdata", m_wdata, wexp);
                end
            end
            if (if_rvalid || d_rvalid) begin
                got = 1;
                chk("resp_cycle", k, kexp);
                chk("resp_chan", {30'h0, if_rvalid, d_rvalid}, isf ? 32'd2 : 32'd1);
                chk("resp_data", isf ? if_rdata : d_rdata, rexp);
                chk("resp_err", {31'h0, isf ? if_err : d_err}, {31'h0, mis || terr});
                chk("resp_mreq", {31'h0, m_req}, 32'h0);
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!got) chk("resp_missing", 32'h0, 32'h1);
        m_gnt = 1'b0; m_rvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int n, streak;
        bit exp_if, isf, we;
        logic [2:0] f3;

        nreset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_m_req", {31'h0, m_req}, 32'h0);
        chk("rst_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        nreset = 1'b1;
        @(posedge clk); #1;

        txn(1, 0, 3'b010, 32'h100, 0, 32'h00500093, 0, 1);
        txn(0, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 1);
        txn(0, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 0, 1);
        txn(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 1);
        txn(0, 0, 3'b010, 32'h201, 0, 32'h12345678, 0, 1);
        txn(0, 0, 3'b011, 32'h200, 0, 32'h12345678, 0, 1);
        txn(0, 0, 3'b001, 32'h302, 0, 32'hC0018000, 1, 0);
        txn(0, 1, 3'b000, 32'h401, 32'h000000A5, 32'h0, 2, 3);
        txn(1, 0, 3'b010, 32'h500, 0, 32'h0, 500, 0);
        txn(0, 0, 3'b010, 32'h600, 0, 32'h0, 0, 500);

        for (int t = 0; t < 40; t++) begin
            isf = ($urandom_range(0, 3) == 0);
            we  = 1'($urandom);
            f3  = 3'($urandom_range(0, 7));
            if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
            txn(isf, we, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        if_req = 1'b1; if_addr = 32'h700;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h800;
        streak = 0;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            #1;
            while (!(if_gnt || d_gnt) && n < 10) begin
                @(posedge clk); #2;
                n++;
            end
            exp_if = (streak == 4);
            chk("arb_order", {30'h0, if_gnt, d_gnt}, exp_if ? 32'd2 : 32'd1);
            streak = exp_if ? 0 : (streak < 4 ? streak + 1 : 4);
            @(posedge clk); #1; m_gnt = 1'b1;
            @(posedge clk); #1; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11112222;
            @(posedge clk); #1; m_rvalid = 1'b0;
            #1;
            chk("arb_resp", {28'h0, if_rvalid, d_rvalid, if_gnt, d_gnt}, exp_if ? 32'd8 : 32'd4);
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        if_req = 1'b1; if_addr = 32'h900;
        #1;
        chk("rst_txn_gnt", {31'h0, if_gnt}, 32'h1);
        @(posedge clk); #1; if_req = 1'b0; m_gnt = 1'b1;
        @(posedge clk); #1; m_gnt = 1'b0;
        #1;
        chk("rst_txn_busy", {31'h0, busy}, 32'h1);
        nreset = 1'b0;
        #1;
        chk("rst_async_busy", {31'h0, busy}, 32'h0);
        chk("rst_async_mreq", {31'h0, m_req}, 32'h0);
        @(posedge clk); #1;
        nreset = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ignored", {29'h0, if_rvalid, d_rvalid, busy}, 32'h0);
        @(posedge clk); #2;
        chk("late_rvalid_quiet", {29'h0, if_rvalid, d_rvalid, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
